// File: rtl/equiv_miter_monitor.sv
// Clocked equivalence miter: aligns two implementation outputs, masks don't-cares,
// and reports mismatch/fail/first-failure/counters. Define EQUIV_MITER_ASSERT_EN for an inline assertion.
module equiv_miter_monitor #(
  parameter int WIDTH        = 91,
  parameter int LAT_A        = 0,
  parameter int LAT_B        = 0,
  parameter int WARMUP       = 4,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] y_a,
  input  logic [WIDTH-1:0] y_b,
  input  logic [WIDTH-1:0] mask,
  output logic             mismatch,
  output logic             fail,
  output logic [CNT_W-1:0] first_cyc,
  output logic [WIDTH-1:0] first_diff,
  output logic [CNT_W-1:0] mis_cnt,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAIL   = 2'd2
  } state_t;

  localparam int WU_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WU_W-1:0] WU_END = WU_W'(WARMUP);

  state_t           state_q, state_d;
  logic [WU_W-1:0]  wu_q, wu_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] mc_q, mc_d;
  logic [CNT_W-1:0] fc_q, fc_d;
  logic [WIDTH-1:0] fd_q, fd_d;
  logic             mis_q, mis_d;
  logic             fail_q, fail_d;

  logic             adv;
  logic [WIDTH-1:0] a_al, b_al, diff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Delay lines stop advancing once the miter has frozen in FAIL.
  assign adv = en && (state_q != ST_FAIL);

  if (LAT_A == 0) begin : g_a_pass
    assign a_al = y_a;
  end else begin : g_a_dly
    logic [WIDTH-1:0] dl_q [LAT_A];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT_A; i++) dl_q[i] <= '0;
      end else if (adv) begin
        dl_q[0] <= y_a;
        for (int i = 1; i < LAT_A; i++) dl_q[i] <= dl_q[i-1];
      end
    end
    assign a_al = dl_q[LAT_A-1];
  end

  if (LAT_B == 0) begin : g_b_pass
    assign b_al = y_b;
  end else begin : g_b_dly
    logic [WIDTH-1:0] dl_q [LAT_B];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT_B; i++) dl_q[i] <= '0;
      end else if (adv) begin
        dl_q[0] <= y_b;
        for (int i = 1; i < LAT_B; i++) dl_q[i] <= dl_q[i-1];
      end
    end
    assign b_al = dl_q[LAT_B-1];
  end

  assign diff = (a_al ^ b_al) & ~mask;

  always_comb begin
    state_d = state_q;
    wu_d    = wu_q;
    chk_d   = chk_q;
    mc_d    = mc_q;
    fc_d    = fc_q;
    fd_d    = fd_q;
    mis_d   = 1'b0;
    fail_d  = fail_q;
    case (state_q)
      ST_WARMUP: begin
        if (WARMUP == 0) begin
          state_d = ST_CHECK;
        end else if (en) begin
          wu_d = wu_q + 1'b1;
          if (wu_d == WU_END) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (en) begin
          chk_d = sat_inc(chk_q);
          mis_d = |diff;
          if (|diff) begin
            mc_d   = sat_inc(mc_q);
            fail_d = 1'b1;
            // First-failure capture uses the pre-increment check index.
            if (!fail_q) begin
              fc_d = chk_q;
              fd_d = diff;
            end
            if (STOP_ON_FAIL != 0) state_d = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_WARMUP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      wu_q    <= '0;
      chk_q   <= '0;
      mc_q    <= '0;
      fc_q    <= '0;
      fd_q    <= '0;
      mis_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wu_q    <= wu_d;
      chk_q   <= chk_d;
      mc_q    <= mc_d;
      fc_q    <= fc_d;
      fd_q    <= fd_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
    end
`ifdef EQUIV_MITER_ASSERT_EN
    if (!rst) assert (mis_q == 1'b0);
`endif
  end

  assign mismatch    = mis_q;
  assign fail        = fail_q;
  assign first_cyc   = fc_q;
  assign first_diff  = fd_q;
  assign mis_cnt     = mc_q;
  assign checked_cnt = chk_q;
  assign state       = state_q;

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// Bench for equiv_miter_monitor: default config table, aligned-latency config,
// and a saturating non-stopping config.
module tb_equiv_miter_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // u0: default parameters
  logic        rst0, en0, mis0, fail0;
  logic [90:0] ya0, yb0, mk0, fd0;
  logic [15:0] fc0, mc0, cc0;
  logic [1:0]  st0;

  equiv_miter_monitor u0 (
    .clk(clk), .rst(rst0), .en(en0), .y_a(ya0), .y_b(yb0), .mask(mk0),
    .mismatch(mis0), .fail(fail0), .first_cyc(fc0), .first_diff(fd0),
    .mis_cnt(mc0), .checked_cnt(cc0), .state(st0)
  );

  // u1: unequal latencies
  logic        rst1, en1, mis1, fail1;
  logic [15:0] ya1, yb1, mk1, fd1, fc1, mc1, cc1;
  logic [1:0]  st1;

  equiv_miter_monitor #(.WIDTH(16), .LAT_A(3), .LAT_B(1), .WARMUP(3)) u1 (
    .clk(clk), .rst(rst1), .en(en1), .y_a(ya1), .y_b(yb1), .mask(mk1),
    .mismatch(mis1), .fail(fail1), .first_cyc(fc1), .first_diff(fd1),
    .mis_cnt(mc1), .checked_cnt(cc1), .state(st1)
  );

  // u2: keep checking, narrow counters
  logic       rst2, en2, mis2, fail2;
  logic [7:0] ya2, yb2, mk2, fd2;
  logic [3:0] fc2, mc2, cc2;
  logic [1:0] st2;

  equiv_miter_monitor #(.WIDTH(8), .STOP_ON_FAIL(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst2), .en(en2), .y_a(ya2), .y_b(yb2), .mask(mk2),
    .mismatch(mis2), .fail(fail2), .first_cyc(fc2), .first_diff(fd2),
    .mis_cnt(mc2), .checked_cnt(cc2), .state(st2)
  );

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [90:0] ya;
    logic [90:0] yb;
    logic [90:0] mk;
    logic        mis;
    logic        fl;
    logic [1:0]  st;
    logic [15:0] cc;
    logic [15:0] mc;
    logic [15:0] fc;
    logic [90:0] fd;
  } vec_t;

  vec_t        tbl[$];
  vec_t        sb0[$];
  logic        sb1[$];
  logic [3:0]  sb2[$];
  logic [90:0] bit90;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [90:0] rnd91();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[90:0];
  endfunction

  // mode 1: equal data; mode 2: single flip of bit 90 on enabled cycle 10; mode 3: same flip, masked
  function automatic void gen(input int mode);
    vec_t v;
    int   k;
    k = 0;
    v = '0;
    v.rst = 1'b1;
    tbl.push_back(v);
    for (int i = 0; i < 24; i++) begin
      v     = '0;
      v.en  = !(i == 2 || i == 15);
      if (v.en) k++;
      v.ya  = rnd91();
      v.yb  = v.ya;
      if (mode != 1 && v.en && k == 10) v.yb = v.ya ^ bit90;
      v.mk  = (mode == 3) ? bit90 : '0;
      v.fl  = (mode == 2) && (k >= 10);
      v.mis = (mode == 2) && v.en && (k == 10);
      v.st  = (k < 4) ? 2'd0 : (v.fl ? 2'd2 : 2'd1);
      v.cc  = (k < 4) ? 16'd0 : ((mode == 2 && k > 10) ? 16'd6 : 16'(k - 4));
      v.mc  = v.fl ? 16'd1 : 16'd0;
      v.fc  = v.fl ? 16'd5 : 16'd0;
      v.fd  = v.fl ? bit90 : '0;
      tbl.push_back(v);
    end
  endfunction

  initial begin
    vec_t        e;
    logic [15:0] ahist [0:63];
    int          npulse;

    bit90     = '0;
    bit90[90] = 1'b1;
    rst0 = 1'b1; en0 = 1'b0; ya0 = '0; yb0 = '0; mk0 = '0;
    rst1 = 1'b1; en1 = 1'b0; ya1 = '0; yb1 = '0; mk1 = '0;
    rst2 = 1'b1; en2 = 1'b0; ya2 = '0; yb2 = '0; mk2 = '0;

    gen(1);
    gen(2);
    gen(3);

    for (int i = 0; i < tbl.size(); i++) begin
      rst0 = tbl[i].rst; en0 = tbl[i].en;
      ya0  = tbl[i].ya;  yb0 = tbl[i].yb; mk0 = tbl[i].mk;
      sb0.push_back(tbl[i]);
      @(posedge clk); #1;
      e = sb0.pop_front();
      cmp("u0.state",       128'(st0),  128'(e.st));
      cmp("u0.mismatch",    128'(mis0), 128'(e.mis));
      cmp("u0.fail",        128'(fail0), 128'(e.fl));
      cmp("u0.checked_cnt", 128'(cc0),  128'(e.cc));
      cmp("u0.mis_cnt",     128'(mc0),  128'(e.mc));
      cmp("u0.first_cyc",   128'(fc0),  128'(e.fc));
      cmp("u0.first_diff",  128'(fd0),  128'(e.fd));
    end

    // u1: B carries A's stream two cycles late, which the latency difference cancels
    @(posedge clk); #1;
    cmp("u1.reset_state", 128'(st1), 128'd0);
    cmp("u1.reset_mis_cnt", 128'(mc1), 128'd0);
    rst1   = 1'b0;
    en1    = 1'b1;
    npulse = 0;
    ahist[0] = '0;
    for (int t = 1; t <= 60; t++) begin
      ahist[t] = 16'($urandom);
      ya1 = ahist[t];
      yb1 = (t >= 3) ? ahist[t-2] : 16'd0;
      if (t == 53) yb1 = yb1 ^ 16'h0100;
      sb1.push_back(t == 54);
      @(posedge clk); #1;
      cmp("u1.mismatch", 128'(mis1), 128'(sb1.pop_front()));
      npulse += int'(mis1);
      if (t == 50) cmp("u1.mis_cnt_clean", 128'(mc1), 128'd0);
    end
    cmp("u1.pulses",      128'(npulse), 128'd1);
    cmp("u1.mis_cnt",     128'(mc1),  128'd1);
    cmp("u1.state",       128'(st1),  128'd2);
    cmp("u1.first_cyc",   128'(fc1),  128'd50);
    cmp("u1.first_diff",  128'(fd1),  128'h0100);
    cmp("u1.checked_cnt", 128'(cc1),  128'd51);

    // u2: persistent difference runs both counters into saturation
    @(posedge clk); #1;
    rst2 = 1'b0;
    en2  = 1'b1;
    ya2  = 8'h00;
    for (int t = 1; t <= 20; t++) begin
      yb2 = (t > 16) ? 8'hF0 : 8'h0F;
      sb2.push_back((t < 5) ? 4'd0 : ((t - 4 > 15) ? 4'd15 : 4'(t - 4)));
      @(posedge clk); #1;
      cmp("u2.mis_cnt",  128'(mc2),  128'(sb2.pop_front()));
      cmp("u2.mismatch", 128'(mis2), 128'(t >= 5));
    end
    cmp("u2.first_cyc",   128'(fc2),   128'd0);
    cmp("u2.first_diff",  128'(fd2),   128'h0F);
    cmp("u2.fail",        128'(fail2), 128'd1);
    cmp("u2.state",       128'(st2),   128'd1);
    cmp("u2.checked_cnt", 128'(cc2),   128'd15);
    en2 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      cmp("u2.idle_mismatch", 128'(mis2), 128'd0);
      cmp("u2.idle_mis_cnt",  128'(mc2),  128'd15);
      cmp("u2.idle_checked",  128'(cc2),  128'd15);
    end
    en2 = 1'b1;
    @(posedge clk); #1;
    cmp("u2.sat_mismatch", 128'(mis2),  128'd1);
    cmp("u2.sat_mis_cnt",  128'(mc2),   128'd15);
    cmp("u2.sat_fail",     128'(fail2), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
